// File: rtl/psk_symbol_mapper_if.sv
// Stream bundle around the PSK symbol mapper.
// Byte side:   mode, s_tdata, s_tvalid (towards mapper), s_tready (from mapper).
// Sample side: I_tdata, Q_tdata, I_tvalid, Q_tvalid (from mapper).
// master = byte source / sample sink, slave = the mapper itself.
interface psk_symbol_mapper_if #(
    parameter int WIDTH = 16
) ();
    logic                    mode;
    logic [7:0]              s_tdata;
    logic                    s_tvalid;
    logic                    s_tready;
    logic signed [WIDTH-1:0] I_tdata;
    logic signed [WIDTH-1:0] Q_tdata;
    logic                    I_tvalid;
    logic                    Q_tvalid;

    modport master (
        output mode, s_tdata, s_tvalid,
        input  s_tready, I_tdata, Q_tdata, I_tvalid, Q_tvalid
    );

    modport slave (
        input  mode, s_tdata, s_tvalid,
        output s_tready, I_tdata, Q_tdata, I_tvalid, Q_tvalid
    );
endinterface

// File: rtl/psk_symbol_mapper.sv
// Transmit-side BPSK/QPSK symbol mapper. Bytes accepted over valid/ready are shifted out
// MSB-first as bits (BPSK) or dibits (QPSK); each symbol becomes a signed +/-AMP I/Q point
// held for SPS samples. Detector inverse: QPSK {b1,b0} = {sign(I), sign(Q)}, BPSK b = sign(I+Q).
// Ports:
//   clk         system clock
//   rst_32M768  synchronous active-high reset
//   bus         slave view: mode/s_tdata/s_tvalid in, s_tready out (combinational),
//               I_tdata/Q_tdata/I_tvalid/Q_tvalid out (registered)
module psk_symbol_mapper #(
    parameter int          WIDTH = 16,
    parameter int          AMP   = 8192,
    parameter int unsigned SPS   = 4
) (
    input logic                clk,
    input logic                rst_32M768,
    psk_symbol_mapper_if.slave bus
);

    localparam int unsigned SmpW = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [SmpW-1:0] SmpLast = SmpW'(SPS - 1);
    localparam logic signed [WIDTH-1:0] AmpPos = WIDTH'(AMP);
    // AMP <= 2^(WIDTH-1)-1, so the negation always fits.
    localparam logic signed [WIDTH-1:0] AmpNeg = -AmpPos;

    typedef enum logic {StIdle, StSend} state_e;

    state_e                  state_q, state_d;
    logic [7:0]              sr_q, sr_d;
    logic                    m_q, m_d;
    logic [2:0]              sym_cnt_q, sym_cnt_d;
    logic [SmpW-1:0]         smp_cnt_q, smp_cnt_d;
    logic signed [WIDTH-1:0] i_q, i_d;
    logic signed [WIDTH-1:0] q_q, q_d;
    logic                    vld_q, vld_d;

    logic smp_last;
    logic sym_last;
    logic end_of_byte;
    logic ready;
    logic accept;

    always_comb begin
        smp_last    = (smp_cnt_q == SmpLast);
        sym_last    = (sym_cnt_q == (m_q ? 3'd3 : 3'd7));
        end_of_byte = (state_q == StSend) && smp_last && sym_last;
        // Held low during reset so no byte is taken on the reset edge.
        ready       = !rst_32M768 && ((state_q == StIdle) || end_of_byte);
        accept      = bus.s_tvalid && ready;
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        m_d       = m_q;
        sym_cnt_d = sym_cnt_q;
        smp_cnt_d = smp_cnt_q;

        if (accept) begin
            state_d   = StSend;
            sr_d      = bus.s_tdata;
            m_d       = bus.mode;
            sym_cnt_d = '0;
            smp_cnt_d = '0;
        end else if (end_of_byte) begin
            state_d   = StIdle;
            sym_cnt_d = '0;
            smp_cnt_d = '0;
        end else if (state_q == StSend) begin
            if (smp_last) begin
                smp_cnt_d = '0;
                sym_cnt_d = sym_cnt_q + 3'd1;
                sr_d      = m_q ? {sr_q[5:0], 2'b00} : {sr_q[6:0], 1'b0};
            end else begin
                smp_cnt_d = smp_cnt_q + 1'b1;
            end
        end

        // Samples are mapped from next-state so an accepted byte appears right after its edge.
        vld_d = (state_d == StSend);
        i_d   = '0;
        q_d   = '0;
        if (state_d == StSend) begin
            i_d = sr_d[7] ? AmpNeg : AmpPos;
            q_d = (m_d ? sr_d[6] : sr_d[7]) ? AmpNeg : AmpPos;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_32M768) begin
            state_q   <= StIdle;
            sr_q      <= '0;
            m_q       <= 1'b0;
            sym_cnt_q <= '0;
            smp_cnt_q <= '0;
            i_q       <= '0;
            q_q       <= '0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            m_q       <= m_d;
            sym_cnt_q <= sym_cnt_d;
            smp_cnt_q <= smp_cnt_d;
            i_q       <= i_d;
            q_q       <= q_d;
            vld_q     <= vld_d;
        end
    end

    assign bus.s_tready = ready;
    assign bus.I_tdata  = i_q;
    assign bus.Q_tdata  = q_q;
    assign bus.I_tvalid = vld_q;
    assign bus.Q_tvalid = vld_q;

endmodule

// File: tb/tb_psk_symbol_mapper.sv
// Self-checking bench for psk_symbol_mapper: fixed vector table, hand-written corner
// sequences, and a random stream checked against a sample-queue model and a loopback detector.
module tb_psk_symbol_mapper;

    localparam int          WIDTH = 16;
    localparam int          AMP   = 8192;
    localparam int unsigned SPS   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    psk_symbol_mapper_if #(.WIDTH(WIDTH)) bus ();

    psk_symbol_mapper #(
        .WIDTH(WIDTH),
        .AMP  (AMP),
        .SPS  (SPS)
    ) dut (
        .clk       (clk),
        .rst_32M768(rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int i;
        int q;
    } smp_t;

    typedef struct {
        logic [7:0] data;
        logic       mode;
    } byte_t;

    typedef struct {
        logic [7:0] data;
        logic       mode;
        logic [7:0] si;  // I sign per symbol, MSB = first symbol, 1 = negative
        logic [7:0] sq;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int accepted = 0;

    smp_t  exp_q[$];
    byte_t tx_q[$];
    int    rx_smp = 0;
    int    rx_sym = 0;
    logic [7:0] rx_byte = '0;

    logic signed [31:0] obs_i, obs_q;
    logic obs_v, obs_qv, obs_rdy;

    vec_t vecs[6];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: the full sample sequence a byte must produce.
    task automatic push_byte(input logic [7:0] d, input logic md);
        int v;
        int nsym;
        smp_t s;
        v = int'(d);
        nsym = md ? 4 : 8;
        for (int k = 0; k < nsym; k++) begin
            if (md) begin
                int di;
                di = (v >> (6 - 2 * k)) % 4;
                s.i = (di / 2 != 0) ? -AMP : AMP;
                s.q = (di % 2 != 0) ? -AMP : AMP;
            end else begin
                int b;
                b = (v >> (7 - k)) % 2;
                s.i = (b != 0) ? -AMP : AMP;
                s.q = s.i;
            end
            for (int r = 0; r < int'(SPS); r++) exp_q.push_back(s);
        end
    endtask

    // Receive-side hard decision at mid-symbol, rebuilding bytes MSB-first.
    task automatic detect();
        logic md;
        if (rx_smp % int'(SPS) == int'(SPS) / 2) begin
            if (tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_orphan: got symbol with no byte pending, expected none");
            end else begin
                md = tx_q[0].mode;
                if (!md) rx_byte = {rx_byte[6:0], ((obs_i + obs_q) < 0)};
                else     rx_byte = {rx_byte[5:0], (obs_i < 0), (obs_q < 0)};
                rx_sym++;
                if (rx_sym == (md ? 4 : 8)) begin
                    check("loopback", rx_byte, tx_q[0].data);
                    void'(tx_q.pop_front());
                    rx_sym = 0;
                end
            end
        end
        rx_smp++;
    endtask

    // One clock cycle: check registered outputs, drive inputs, check ready, advance model.
    task automatic cycle(input logic r, input logic v, input logic [7:0] d, input logic md);
        smp_t e;
        logic exp_rdy;
        @(negedge clk);
        obs_v  = bus.I_tvalid;
        obs_qv = bus.Q_tvalid;
        obs_i  = bus.I_tdata;
        obs_q  = bus.Q_tdata;
        if (exp_q.size() > 0) e = exp_q[0];
        else                  e = '{0, 0};
        check("I_tvalid", obs_v, exp_q.size() > 0);
        check("Q_tvalid", obs_qv, exp_q.size() > 0);
        check("I_tdata", obs_i, e.i);
        check("Q_tdata", obs_q, e.q);
        if (obs_v === 1'b1) detect();

        rst          = r;
        bus.s_tvalid = v;
        bus.s_tdata  = d;
        bus.mode     = md;
        #1;
        obs_rdy = bus.s_tready;
        exp_rdy = !r && (exp_q.size() <= 1);
        check("s_tready", obs_rdy, exp_rdy);

        if (r) begin
            exp_q.delete();
            tx_q.delete();
            rx_smp  = 0;
            rx_sym  = 0;
            rx_byte = '0;
        end else begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (v && exp_rdy) begin
                push_byte(d, md);
                tx_q.push_back('{d, md});
                accepted++;
            end
        end
    endtask

    initial begin
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = '0;
        bus.mode     = 1'b0;

        vecs[0] = '{8'hA5, 1'b0, 8'hA5, 8'hA5};
        vecs[1] = '{8'hB4, 1'b1, 8'hC0, 8'h60};
        vecs[2] = '{8'h00, 1'b0, 8'h00, 8'h00};
        vecs[3] = '{8'hFF, 1'b1, 8'hF0, 8'hF0};
        vecs[4] = '{8'h3C, 1'b1, 8'h60, 8'h60};
        vecs[5] = '{8'h96, 1'b0, 8'h96, 8'h96};

        repeat (2) @(posedge clk);

        // Reset held for 3 cycles, then ready on the first released cycle.
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, 1'b0, 8'h00, 1'b0);
            check("rst_ready", obs_rdy, 1'b0);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check("rel_ready", obs_rdy, 1'b1);

        // Vector table; mode is toggled throughout each byte and must not matter.
        for (int n = 0; n < 6; n++) begin
            int nsmp;
            nsmp = (vecs[n].mode ? 4 : 8) * int'(SPS);
            cycle(1'b0, 1'b1, vecs[n].data, vecs[n].mode);
            for (int c = 0; c < nsmp; c++) begin
                int sym;
                sym = c / int'(SPS);
                cycle(1'b0, 1'b0, 8'h00, ~vecs[n].mode);
                check("tbl_valid", obs_v, 1'b1);
                check("tbl_I", obs_i, vecs[n].si[7 - sym] ? -AMP : AMP);
                check("tbl_Q", obs_q, vecs[n].sq[7 - sym] ? -AMP : AMP);
            end
            cycle(1'b0, 1'b0, 8'h00, 1'b0);
            check("tbl_idle", obs_v, 1'b0);
        end

        // Back-to-back QPSK 0x00 then 0xFF with valid held.
        cycle(1'b0, 1'b1, 8'h00, 1'b1);
        for (int c = 0; c < 32; c++) begin
            cycle(1'b0, (c <= 15), 8'hFF, 1'b1);
            check("b2b_valid", obs_v, 1'b1);
            check("b2b_ready", obs_rdy, (c == 15) || (c == 31));
            check("b2b_I", obs_i, (c < 16) ? AMP : -AMP);
            check("b2b_Q", obs_q, (c < 16) ? AMP : -AMP);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check("b2b_idle", obs_v, 1'b0);

        // One-cycle gap in valid at byte end gives exactly one idle cycle.
        cycle(1'b0, 1'b1, 8'h0F, 1'b1);
        for (int c = 0; c < 16; c++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b1, 8'hF0, 1'b1);
        check("gap_valid", obs_v, 1'b0);
        check("gap_I", obs_i, 0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("gap_resume", obs_v, 1'b1);
        for (int c = 0; c < 16; c++) cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Mode toggles mid-byte, then reset at sample 10 of a BPSK byte.
        cycle(1'b0, 1'b1, 8'h5A, 1'b0);
        for (int c = 0; c < 10; c++) begin
            int b;
            b = (int'(8'h5A) >> (7 - c / int'(SPS))) % 2;
            cycle(1'b0, 1'b0, 8'h00, 1'(c % 2));
            check("mid_I", obs_i, (b != 0) ? -AMP : AMP);
            check("mid_Q", obs_q, (b != 0) ? -AMP : AMP);
        end
        cycle(1'b1, 1'b1, 8'h33, 1'b1);
        check("mid_rst_ready", obs_rdy, 1'b0);
        cycle(1'b1, 1'b1, 8'h33, 1'b1);
        check("mid_rst_valid", obs_v, 1'b0);
        check("mid_rst_I", obs_i, 0);
        check("mid_rst_Q", obs_q, 0);
        cycle(1'b0, 1'b1, 8'hB4, 1'b1);
        for (int c = 0; c < 16; c++) begin
            int sym;
            sym = c / int'(SPS);
            cycle(1'b0, 1'b0, 8'h00, 1'b0);
            check("post_rst_I", obs_i, vecs[1].si[7 - sym] ? -AMP : AMP);
            check("post_rst_Q", obs_q, vecs[1].sq[7 - sym] ? -AMP : AMP);
        end

        // Random 64-byte stream with random mode and random valid gaps.
        accepted = 0;
        for (int n = 0; n < 5000 && accepted < 64; n++) begin
            cycle(1'b0, ($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        if (accepted < 64) begin
            checks++;
            errors++;
            $display("FAIL rand_timeout: accepted %0d expected 64", accepted);
        end
        for (int c = 0; c < 40; c++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check("rx_drain", tx_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psk_symbol_mapper.md
# psk_symbol_mapper

Transmit-side BPSK/QPSK symbol mapper. It accepts bytes over a valid/ready handshake and serialises them MSB-first into bits or dibits. Each symbol is mapped to a signed I/Q constellation point and held for `SPS` clock cycles. Its output is the exact inverse of the receive-side hard-decision detector:
- QPSK bits `{b1,b0}` are recovered as `{sign(I), sign(Q)}`.
- BPSK bit `b` is recovered as `sign(I+Q)`.

The block sits between the framing/data source and the pulse-shaping/upconversion chain.

## Interface
Parameters:
- `WIDTH`, 16: I/Q sample width, signed two's complement.
- `AMP`, 8192: constellation magnitude. Must satisfy 0 < `AMP` ≤ 2^(`WIDTH`-1)-1.
- `SPS`, 4: clock cycles (samples) per symbol, ≥ 1.

Ports:
- `clk`  in  1  system clock; one clock domain only.
- `rst_32M768`  in  1  reset, synchronous, active-high.
- `mode`  in  1  0 = BPSK, 1 = QPSK; sampled only at byte acceptance.
- `s_tdata`  in  8  input byte.
- `s_tvalid`  in  1  input byte valid.
- `s_tready`  out  1  block can accept a byte this cycle.
- `I_tdata`  out  `WIDTH`  signed I sample.
- `Q_tdata`  out  `WIDTH`  signed Q sample.
- `I_tvalid`  out  1  I sample valid.
- `Q_tvalid`  out  1  Q sample valid; always equal to `I_tvalid`.

## Operation
- State machine states:
  - IDLE: no byte loaded.
  - SEND: byte loaded and being emitted.
- Internal registers: 8-bit shift register `sr`, latched mode `m`, symbol counter `sym_cnt` (0..7 for BPSK, 0..3 for QPSK), sample counter `smp_cnt` (0..`SPS`-1).
- `s_tready` (combinational) is 1 when either:
  - state is IDLE, or
  - state is SEND and `smp_cnt`=`SPS`-1 and `sym_cnt` is the last symbol (7 for BPSK, 3 for QPSK).
- Acceptance happens when `s_tvalid` && `s_tready`:
  - `sr` ← `s_tdata`, `m` ← `mode`, both counters ← 0, state ← SEND.
  - The first symbol is mapped from `s_tdata` directly, so there is no gap.
- BPSK mapping, bit b = `sr[7]`:
  - I = Q = (b ? -`AMP` : +`AMP`).
  - Advancing to the next symbol: `sr` shifts left by 1.
- QPSK mapping, dibit `{b1,b0}` = `sr[7:6]`:
  - I = (b1 ? -`AMP` : +`AMP`), Q = (b0 ? -`AMP` : +`AMP`).
  - Advancing to the next symbol: `sr` shifts left by 2.
- Counters:
  - `smp_cnt` increments every SEND cycle and wraps at `SPS`-1.
  - On the wrap, `sym_cnt` increments and `sr` shifts.
- End of byte (last sample of last symbol):
  - If a new byte is accepted in the same cycle, stay in SEND with seamless continuation.
  - Otherwise go to IDLE.
- Changes on `mode` while in SEND are ignored until the next acceptance.
- In IDLE: `I_tdata` = `Q_tdata` = 0 and `I_tvalid` = `Q_tvalid` = 0.
- Arithmetic: −`AMP` is formed in `WIDTH` bits and never overflows, given the `AMP` constraint.

## Timing
- All outputs except `s_tready` are registered.
- Reset values: `I_tdata` = 0, `Q_tdata` = 0, `I_tvalid` = 0, `Q_tvalid` = 0, state IDLE, counters 0, `sr` = 0.
- `s_tready` = 1 on the first cycle after reset is released.
- Latency: for a byte accepted at clock edge k, the first sample is valid in the cycle following edge k, i.e. 1 cycle.
- Byte durations, with every sample valid:
  - BPSK: 8·`SPS` cycles.
  - QPSK: 4·`SPS` cycles.
- Back-to-back bytes produce a continuous `tvalid` with no bubble.
- A 1-cycle gap in `s_tvalid` at byte end produces exactly 1 idle cycle: `tvalid` = 0, samples 0.
- Reset asserted mid-byte: the loaded byte is discarded.
  - Outputs are 0 and `tvalid` is 0 in the cycle after the reset edge.
  - `s_tready` is held at 0 while reset is asserted.
- Mode change on the acceptance cycle takes effect for that byte. Mode change on any other cycle has no effect on the byte in flight.

## Test plan
- **Reset:** assert reset for 3 cycles -> outputs 0, `tvalid` 0, `s_tready` 0 during reset and 1 after release.
- **BPSK:** `SPS`=4, `AMP`=8192, `mode`=0, single byte 0xA5 -> 32 valid cycles.
  - I = Q sign sequence per 4-cycle symbol: −,+,−,+,+,−,+,−.
  - Magnitude 8192.
  - Then IDLE with `tvalid` 0.
- **QPSK:** `mode`=1, byte 0xB4 -> 16 valid cycles.
  - (I,Q) per symbol: (−8192,+8192), (−8192,−8192), (+8192,−8192), (+8192,+8192).
- **Back-to-back:** QPSK 0x00 then 0xFF with `s_tvalid` held high -> 32 contiguous valid cycles.
  - First 16 cycles are (+,+); last 16 are (−,−).
  - `s_tready` pulses exactly at cycles 15 and 31.
- **Mid-byte events:** toggle `mode` mid-byte, then assert reset at cycle 10 of a BPSK byte.
  - The mode toggle does not alter the in-flight mapping.
  - After the reset edge, outputs are 0 and `tvalid` is 0; the next accepted byte starts cleanly.
- **Loopback:** random 64-byte stream with random `mode` per byte, fed into the receive detector and sampled at mid-symbol -> recovered BPSK bits / QPSK dibits match the transmitted data, in MSB-first order.
